// File: rtl/sargantana_itag_memory_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sargantana_itag_memory_param                                      |
// | Brief  : Parametrised icache tag/valid store with per-entry even parity.   |
// |          A post-reset sweep clears all entries, then requests are served.  |
// |          Reads have one cycle of latency. A parity fault on a valid entry   |
// |          is reported and the entry is returned as a miss.                  |
// | Ports  : clk_i        - clock, rising edge                                  |
// |          rst_i        - synchronous active-high reset                      |
// |          req_i        - per-way request (multi-hot allowed)                |
// |          we_i         - 1 = write selected ways, 0 = read selected ways    |
// |          vbit_i       - valid bit to write                                 |
// |          flush_i      - clear every valid bit; same-cycle request dropped  |
// |          err_inj_i    - on write, store inverted parity                    |
// |          data_i       - tag to write                                       |
// |          addr_i       - set index                                          |
// |          tag_way_o    - registered tag per way (way w at [w*TAG_W +: TAG_W])|
// |          vbit_o       - registered valid per way, masked by parity fault   |
// |          parity_err_o - registered parity fault per way                    |
// |          ready_o      - high once the init sweep has finished              |
// | Rev    : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sargantana_itag_memory_param #(
  parameter int N_WAY = 4,
  parameter int DEPTH = 64,
  parameter int TAG_W = 27,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_WAY-1:0]       req_i,
  input  logic                   we_i,
  input  logic                   vbit_i,
  input  logic                   flush_i,
  input  logic                   err_inj_i,
  input  logic [TAG_W-1:0]       data_i,
  input  logic [IDX_W-1:0]       addr_i,
  output logic [N_WAY*TAG_W-1:0] tag_way_o,
  output logic [N_WAY-1:0]       vbit_o,
  output logic [N_WAY-1:0]       parity_err_o,
  output logic                   ready_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int            c_last_int = DEPTH - 1;
  localparam logic [IDX_W:0] c_last_idx = c_last_int[IDX_W:0];
  localparam logic [IDX_W:0] c_one      = {{IDX_W{1'b0}}, 1'b1};

  state_e           state_q;
  logic [IDX_W:0]   idx_q;   // one spare bit so the sweep count never wraps
  logic             ready_q;
  logic [IDX_W-1:0] w_init_idx;

  assign w_init_idx = idx_q[IDX_W-1:0];
  assign ready_o    = ready_q;

  // Init sweep sequencer: one set per cycle, RUN after the last set is cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (idx_q == c_last_idx) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
          idx_q <= idx_q + c_one;
        end
        default: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar w = 0; w < N_WAY; w++) begin : g_way
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [DEPTH-1:0] par_mem_q;
    logic [DEPTH-1:0] valid_mem_q;
    logic [TAG_W-1:0] tag_out_q;
    logic             vbit_out_q;
    logic             perr_out_q;
    logic [TAG_W-1:0] w_rd_tag;
    logic             w_rd_valid;
    logic             w_rd_perr;

    assign w_rd_tag   = tag_mem_q[addr_i];
    assign w_rd_valid = valid_mem_q[addr_i];
    // Even parity mismatch only matters for entries that claim to be valid.
    assign w_rd_perr  = ((^w_rd_tag) ^ par_mem_q[addr_i]) & w_rd_valid;

    // Storage is never reset directly; the init sweep clears it instead.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tag_out_q  <= '0;
        vbit_out_q <= 1'b0;
        perr_out_q <= 1'b0;
      end else if (state_q == ST_INIT) begin
        tag_mem_q[w_init_idx]   <= '0;
        par_mem_q[w_init_idx]   <= 1'b0;
        valid_mem_q[w_init_idx] <= 1'b0;
      end else if (flush_i) begin
        valid_mem_q <= '0;
        vbit_out_q  <= 1'b0;
        perr_out_q  <= 1'b0;
      end else if (req_i[w]) begin
        if (we_i) begin
          tag_mem_q[addr_i]   <= data_i;
          par_mem_q[addr_i]   <= (^data_i) ^ err_inj_i;
          valid_mem_q[addr_i] <= vbit_i;
        end else begin
          tag_out_q  <= w_rd_tag;
          perr_out_q <= w_rd_perr;
          vbit_out_q <= w_rd_valid & ~w_rd_perr;
        end
      end
    end

    assign tag_way_o[w*TAG_W +: TAG_W] = tag_out_q;
    assign vbit_o[w]                   = vbit_out_q;
    assign parity_err_o[w]             = perr_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sargantana_itag_memory_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sargantana_itag_memory_param                                   |
// | Brief  : Scoreboard bench: directed ops push hand-computed expected outputs|
// |          into a queue; a monitor pops and compares after each checked edge.|
// |          A second small instance checks the parametrised init length.      |
// | Rev    : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sargantana_itag_memory_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: N_WAY=4, DEPTH=64, TAG_W=27
  logic         rst, we, vbit, flush, inj;
  logic [3:0]   req;
  logic [26:0]  data;
  logic [5:0]   addr;
  logic [107:0] tag_o;
  logic [3:0]   v_o, p_o;
  logic         rdy;

  sargantana_itag_memory_param #(.N_WAY(4), .DEPTH(64), .TAG_W(27)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .vbit_i(vbit),
    .flush_i(flush), .err_inj_i(inj), .data_i(data), .addr_i(addr),
    .tag_way_o(tag_o), .vbit_o(v_o), .parity_err_o(p_o), .ready_o(rdy)
  );

  // Instance 2: N_WAY=2, DEPTH=16, TAG_W=20
  logic        rst2, we2, vbit2, flush2, inj2;
  logic [1:0]  req2;
  logic [19:0] data2;
  logic [3:0]  addr2;
  logic [39:0] tag2_o;
  logic [1:0]  v2_o, p2_o;
  logic        rdy2;

  sargantana_itag_memory_param #(.N_WAY(2), .DEPTH(16), .TAG_W(20)) dut2 (
    .clk_i(clk), .rst_i(rst2), .req_i(req2), .we_i(we2), .vbit_i(vbit2),
    .flush_i(flush2), .err_inj_i(inj2), .data_i(data2), .addr_i(addr2),
    .tag_way_o(tag2_o), .vbit_o(v2_o), .parity_err_o(p2_o), .ready_o(rdy2)
  );

  typedef struct {
    string        name;
    logic [107:0] tag;
    logic [3:0]   v;
    logic [3:0]   p;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic chk_flag = 1'b0;
  logic chk_seen = 1'b0;

  localparam logic [26:0] Z = 27'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, want);
  endtask

  function automatic logic [107:0] t4(input logic [26:0] a3, input logic [26:0] a2,
                                      input logic [26:0] a1, input logic [26:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  // Monitor: compare the outputs produced by each checked edge.
  always @(posedge clk) chk_seen <= chk_flag;

  always @(negedge clk) begin : mon
    exp_t e;
    if (chk_seen) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_tag"},  128'(tag_o), 128'(e.tag));
        chk({e.name, "_vbit"}, 128'(v_o),   128'(e.v));
        chk({e.name, "_perr"}, 128'(p_o),   128'(e.p));
      end
    end
  end

  task automatic op(input logic [3:0] r, input logic w, input logic vb, input logic fl,
                    input logic ij, input logic [26:0] d, input logic [5:0] a,
                    input logic do_chk, input string nm, input logic [107:0] et,
                    input logic [3:0] ev, input logic [3:0] ep);
    exp_t e;
    req = r; we = w; vbit = vb; flush = fl; inj = ij; data = d; addr = a;
    if (do_chk) begin
      e.name = nm; e.tag = et; e.v = ev; e.p = ep;
      exp_q.push_back(e);
    end
    chk_flag = do_chk;
    @(posedge clk); #1;
    chk_flag = 1'b0;
    req = '0; we = 1'b0; vbit = 1'b0; flush = 1'b0; inj = 1'b0;
  endtask

  task automatic wr(input logic [3:0] r, input logic [26:0] d, input logic [5:0] a,
                    input logic vb, input logic ij);
    op(r, 1'b1, vb, 1'b0, ij, d, a, 1'b0, "", '0, '0, '0);
  endtask

  task automatic rd(input logic [3:0] r, input logic [5:0] a, input string nm,
                    input logic [107:0] et, input logic [3:0] ev, input logic [3:0] ep);
    op(r, 1'b0, 1'b0, 1'b0, 1'b0, '0, a, 1'b1, nm, et, ev, ep);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] td;
    rst = 1'b1; req = 4'hF; we = 1'b0; vbit = 1'b0; flush = 1'b0; inj = 1'b0;
    data = '0; addr = '0;
    rst2 = 1'b1; req2 = '0; we2 = 1'b0; vbit2 = 1'b0; flush2 = 1'b0; inj2 = 1'b0;
    data2 = '0; addr2 = '0;

    // Reset, then INIT with req_i=F held (and flush toggling, both ignored)
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("init_ready", 128'(rdy), 128'd0);
      chk("init_outputs", 128'({tag_o, v_o, p_o}), 128'd0);
      flush = i[0];
      @(posedge clk); #1;
    end
    flush = 1'b0;
    chk("ready_rise_64", 128'(rdy), 128'd1);
    rd(4'hF, 6'd0, "first_read", '0, 4'h0, 4'h0);

    // Write then immediately read back
    wr(4'b0100, 27'h5A5A5A5, 6'd17, 1'b1, 1'b0);
    rd(4'hF, 6'd17, "wr_rd", t4(Z, 27'h5A5A5A5, Z, Z), 4'b0100, 4'b0000);

    // Fault injection then clean rewrite
    wr(4'b0010, 27'h1, 6'd3, 1'b1, 1'b1);
    rd(4'hF, 6'd3, "inj_fault", t4(Z, Z, 27'h1, Z), 4'b0000, 4'b0010);
    wr(4'b0010, 27'h1, 6'd3, 1'b1, 1'b0);
    rd(4'hF, 6'd3, "inj_clean", t4(Z, Z, 27'h1, Z), 4'b0010, 4'b0000);

    // Flush colliding with a write
    for (int s = 0; s < 4; s++) begin
      td = 27'h100 + 27'(s);
      wr(4'hF, td, 6'(s), 1'b1, 1'b0);
    end
    rd(4'hF, 6'd2, "prefill", t4(27'h102, 27'h102, 27'h102, 27'h102), 4'hF, 4'h0);
    op(4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 27'h7777, 6'd5, 1'b1, "flush_out",
       t4(27'h102, 27'h102, 27'h102, 27'h102), 4'h0, 4'h0);
    rd(4'hF, 6'd5, "flush_drop_set5", '0, 4'h0, 4'h0);
    for (int s = 0; s < 4; s++) begin
      td = 27'h100 + 27'(s);
      rd(4'hF, 6'(s), "flushed_set", t4(td, td, td, td), 4'h0, 4'h0);
    end

    // Write holds outputs; partial read; idle holds
    op(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 27'hABC, 6'd6, 1'b1, "write_hold",
       t4(27'h103, 27'h103, 27'h103, 27'h103), 4'h0, 4'h0);
    rd(4'b0001, 6'd6, "partial", t4(27'h103, 27'h103, 27'h103, 27'hABC), 4'b0001, 4'h0);
    op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, '0, 6'd6, 1'b1, "idle_hold",
       t4(27'h103, 27'h103, 27'h103, 27'hABC), 4'b0001, 4'h0);

    // Injected parity on an invalid entry is not a fault
    wr(4'b1000, 27'h3, 6'd8, 1'b0, 1'b1);
    rd(4'b1000, 6'd8, "inj_invalid", t4(27'h3, 27'h103, 27'h103, 27'hABC), 4'b0001, 4'h0);

    // Highest set index
    wr(4'b0001, 27'h7FFFFFF, 6'd63, 1'b1, 1'b0);
    rd(4'b0001, 6'd63, "last_set", t4(27'h3, 27'h103, 27'h103, 27'h7FFFFFF), 4'b0001, 4'h0);

    // Reset from RUN, then again at init cycle 30
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_from_run", 128'({tag_o, v_o, p_o, rdy}), 128'd0);
    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("reinit_ready", 128'(rdy), 128'd0);
      @(posedge clk); #1;
    end
    chk("ready_after_second_reset", 128'(rdy), 128'd1);
    rd(4'hF, 6'd17, "post_reset_read", '0, 4'h0, 4'h0);
    @(posedge clk); #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    // Small instance: mid-init reset, then 16-cycle init
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("p2_init_ready", 128'(rdy2), 128'd0);
      @(posedge clk); #1;
    end
    chk("p2_ready_rise_16", 128'(rdy2), 128'd1);
    req2 = 2'b10; we2 = 1'b1; vbit2 = 1'b1; data2 = 20'hABCDE; addr2 = 4'd15;
    @(posedge clk); #1;
    req2 = 2'b11; we2 = 1'b0; vbit2 = 1'b0;
    @(posedge clk); #1;
    req2 = 2'b00;
    chk("p2_tag", 128'(tag2_o), 128'({20'hABCDE, 20'h0}));
    chk("p2_vbit", 128'(v2_o), 128'd2);
    chk("p2_perr", 128'(p2_o), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
